pr_stream_packer: RTL

Producer side of the 64-bit tagged word stream that the PageRank fetch/compute block consumes from its input FIFO. On a start pulse, the block walks three local source memories and emits one tagged word per entry:
- pagerank table (tag 00),
- out-degree table (tag 01),
- a terminator word (tag 11),
- one untagged edge-range word per node, built from a row-pointer table.

Output uses a valid/ready handshake into the input FIFO write side.

---
 rtl/pr_stream_packer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/pr_stream_packer.sv
// Producer for the PageRank input stream: walks the pagerank, out-degree and
// row-pointer memories and emits tagged 64-bit words over a valid/ready handshake.
module pr_stream_packer #(
  parameter int NODES = 256,
  parameter int AW    = 8,
  parameter int RPW   = 30
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   num_nodes,
  output logic [AW-1:0] pr_addr,
  input  logic [31:0]   pr_data,
  output logic [AW-1:0] od_addr,
  input  logic [31:0]   od_data,
  output logic [AW:0]   rp_addr,
  input  logic [RPW-1:0] rp_data,
  output logic [63:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  localparam int IPAD = 30 - AW;
  localparam int NPAD = 32 - (AW + 1);
  localparam int RPAD = 32 - RPW;

  typedef enum logic [3:0] {
    IDLE, PR_REQ, PR_CAP, PR_OUT, OD_REQ, OD_CAP, OD_OUT,
    TERM, RP0_REQ, RP0_CAP, RP_REQ, RP_CAP, RP_OUT, FIN
  } state_t;

  state_t         state_q, state_d;
  logic [AW:0]    n_q, n_d;
  logic [AW:0]    i_q, i_d;
  logic [AW:0]    rp_addr_q, rp_addr_d;
  logic [RPW-1:0] prev_rp_q, prev_rp_d;
  logic [RPW-1:0] cur_rp_q, cur_rp_d;
  logic [63:0]    out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           hs;
  logic           last;
  logic [AW:0]    i_inc;
  logic [AW:0]    n_clip;

  assign hs     = out_valid_q && out_ready;
  assign i_inc  = i_q + 1'b1;
  assign last   = (i_inc == n_q);
  assign n_clip = (num_nodes > (AW+1)'(NODES)) ? (AW+1)'(NODES) : num_nodes;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    i_d         = i_q;
    rp_addr_d   = rp_addr_q;
    prev_rp_d   = prev_rp_q;
    cur_rp_d    = cur_rp_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = n_clip;
          i_d     = '0;
          busy_d  = 1'b1;
          state_d = (n_clip != '0) ? PR_REQ : TERM;
        end
      end
      PR_REQ: state_d = PR_CAP;
      PR_CAP: begin
        out_data_d  = {2'b00, {IPAD{1'b0}}, i_q[AW-1:0], pr_data};
        out_valid_d = 1'b1;
        state_d     = PR_OUT;
      end
      PR_OUT: begin
        if (hs) begin
          out_valid_d = 1'b0;
          i_d         = last ? '0 : i_inc;
          state_d     = last ? OD_REQ : PR_REQ;
        end
      end
      OD_REQ: state_d = OD_CAP;
      OD_CAP: begin
        out_data_d  = {2'b01, {IPAD{1'b0}}, i_q[AW-1:0], od_data};
        out_valid_d = 1'b1;
        state_d     = OD_OUT;
      end
      OD_OUT: begin
        if (hs) begin
          out_valid_d = 1'b0;
          i_d         = last ? '0 : i_inc;
          state_d     = last ? TERM : OD_REQ;
        end
      end
      // Terminator is loaded in the first TERM cycle, then held until accepted.
      TERM: begin
        if (!out_valid_q) begin
          out_data_d  = {2'b11, 30'b0, {NPAD{1'b0}}, n_q};
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          if (n_q == '0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = FIN;
          end else begin
            rp_addr_d = '0;
            state_d   = RP0_REQ;
          end
        end
      end
      RP0_REQ: state_d = RP0_CAP;
      RP0_CAP: begin
        prev_rp_d = rp_data;
        i_d       = '0;
        rp_addr_d = (AW+1)'(1);
        state_d   = RP_REQ;
      end
      RP_REQ: state_d = RP_CAP;
      RP_CAP: begin
        cur_rp_d    = rp_data;
        out_data_d  = {{RPAD{1'b0}}, rp_data, {RPAD{1'b0}}, prev_rp_q};
        out_valid_d = 1'b1;
        state_d     = RP_OUT;
      end
      RP_OUT: begin
        if (hs) begin
          out_valid_d = 1'b0;
          prev_rp_d   = cur_rp_q;
          if (last) begin
            i_d     = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = FIN;
          end else begin
            i_d       = i_inc;
            rp_addr_d = i_inc + 1'b1;
            state_d   = RP_REQ;
          end
        end
      end
      FIN: begin
        rp_addr_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      n_q         <= '0;
      i_q         <= '0;
      rp_addr_q   <= '0;
      prev_rp_q   <= '0;
      cur_rp_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      i_q         <= i_d;
      rp_addr_q   <= rp_addr_d;
      prev_rp_q   <= prev_rp_d;
      cur_rp_q    <= cur_rp_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pr_addr   = i_q[AW-1:0];
  assign od_addr   = i_q[AW-1:0];
  assign rp_addr   = rp_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
